// File: rtl/tlu_event_packer.sv
// Trigger event packer: queues {trig_id, time_stamp, trig_le} records and serialises each into four 32-bit FIFO words.
// Optional feature macro: TLU_EVENT_LOST_CNT_EN enables the saturating lost-trigger counter and its header snapshot.
module tlu_event_packer #(
    parameter int QUEUE_DEPTH_LOG2 = 2
) (
    input  logic        clk40,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        trig,
    input  logic [31:0] trig_id,
    input  logic [63:0] time_stamp,
    input  logic [7:0]  trig_le,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [31:0] fifo_data,
    output logic        busy,
    output logic        queue_full,
    output logic [7:0]  lost_data_cnt
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG2;
    localparam logic [QUEUE_DEPTH_LOG2:0] DEPTH_CNT = (QUEUE_DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

    state_t                      state_reg;
    logic [QUEUE_DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [QUEUE_DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [QUEUE_DEPTH_LOG2:0]   count_reg;

    // Only the transmitted bits are stored; the dropped top bits are parked here.
    logic [30:0] id_mem [DEPTH];
    logic [61:0] ts_mem [DEPTH];
    logic [7:0]  le_mem [DEPTH];
    logic        unused_bits;

    logic [30:0] id_reg;
    logic [61:0] ts_reg;
    logic [7:0]  le_reg;
    logic [7:0]  lost_snap;

    logic queue_empty;
    logic push;
    logic drop;
    logic pop;

    assign unused_bits = ^{trig_id[31], time_stamp[63:62]};

    assign queue_empty = (count_reg == '0);
    assign queue_full  = (count_reg == DEPTH_CNT);
    assign push        = trig && enable && !queue_full && !clear;
    assign drop        = trig && enable && queue_full && !clear;
    assign fifo_write  = (state_reg != IDLE) && !fifo_full;
    assign pop         = !clear && !queue_empty &&
                         ((state_reg == IDLE) || ((state_reg == W3) && fifo_write));
    assign busy        = !queue_empty || (state_reg != IDLE);

    always_ff @(posedge clk40) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= trig_id[30:0];
            ts_mem[wr_ptr_reg] <= time_stamp[61:0];
            le_mem[wr_ptr_reg] <= trig_le;
        end
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            id_reg     <= '0;
            ts_reg     <= '0;
            le_reg     <= '0;
        end else if (clear) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{QUEUE_DEPTH_LOG2{1'b0}}, push}
                                   - {{QUEUE_DEPTH_LOG2{1'b0}}, pop};
            if (pop) begin
                id_reg <= id_mem[rd_ptr_reg];
                ts_reg <= ts_mem[rd_ptr_reg];
                le_reg <= le_mem[rd_ptr_reg];
            end
            case (state_reg)
                IDLE:    if (pop) state_reg <= W0;
                W0:      if (fifo_write) state_reg <= W1;
                W1:      if (fifo_write) state_reg <= W2;
                W2:      if (fifo_write) state_reg <= W3;
                W3:      if (fifo_write) state_reg <= pop ? W0 : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef TLU_EVENT_LOST_CNT_EN
    logic [7:0] lost_reg;
    logic [7:0] lost_snap_reg;

    // The count restarts at every header; a drop on the snapshot edge counts toward the next one.
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            lost_reg      <= '0;
            lost_snap_reg <= '0;
        end else if (clear) begin
            lost_reg      <= '0;
        end else if (pop) begin
            lost_snap_reg <= lost_reg;
            lost_reg      <= drop ? 8'd1 : 8'd0;
        end else if (drop && (lost_reg != 8'hff)) begin
            lost_reg      <= lost_reg + 8'd1;
        end
    end

    assign lost_data_cnt = lost_reg;
    assign lost_snap     = lost_snap_reg;
`else
    assign lost_data_cnt = 8'd0;
    assign lost_snap     = 8'd0;
`endif

    always_comb begin
        fifo_data = 32'd0;
        case (state_reg)
            W0:      fifo_data = {1'b1, 7'd0, le_reg, 8'd0, lost_snap};
            W1:      fifo_data = {1'b0, id_reg};
            W2:      fifo_data = {1'b0, ts_reg[30:0]};
            W3:      fifo_data = {1'b0, ts_reg[61:31]};
            default: fifo_data = 32'd0;
        endcase
    end

endmodule
